// File: rtl/cpu_pkg.sv
// Shared CPU types and widths: instruction/address sizes, decode field sizes,
// and the fetch buffer entry.
package cpu_pkg;

  localparam int unsigned A_WIDTH = 32;
  localparam int unsigned D_WIDTH = 32;
  localparam logic [A_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  localparam int unsigned OPCODE_WIDTH = 7;
  localparam int unsigned FUNCT3_WIDTH = 3;
  localparam int unsigned FUNCT7_WIDTH = 7;
  // major opcode field, opcode[6:2]
  localparam int unsigned OP_WIDTH     = 5;

  typedef struct packed {
    logic [A_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch instruction buffer: synchronous FIFO of {pc, instr} entries with
// flush (priority over push) and an occupancy count.
module fetch_fifo import cpu_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests to imem, in-order
// response buffering with PCs, and redirect flush with stale-response discard.
module fetch_unit #(
  parameter int unsigned        A_WIDTH    = cpu_pkg::A_WIDTH,
  parameter int unsigned        D_WIDTH    = cpu_pkg::D_WIDTH,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [A_WIDTH-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               isu_valid,
  input  logic               isu_ready,
  output logic [D_WIDTH-1:0] isu_data,
  output logic [A_WIDTH-1:0] isu_pc,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc
);

  import cpu_pkg::fetch_entry_t;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 2;

  logic [A_WIDTH-1:0] fetch_pc;
  logic [A_WIDTH-1:0] rsp_pc;
  logic [A_WIDTH-1:0] target_pc;
  logic [CW-1:0]      occupancy;
  logic [CW-1:0]      live_cnt;
  logic [CW-1:0]      discard_cnt;
  logic [SW-1:0]      in_use;
  logic               req_fire;
  logic               rsp_drop;
  logic               rsp_live;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  assign target_pc = {redirect_pc[A_WIDTH-1:2], 2'b00};

  // Buffered, live and to-be-discarded slots all hold a credit, so a push
  // can never find the buffer full.
  assign in_use         = SW'(occupancy) + SW'(live_cnt) + SW'(discard_cnt);
  assign imem_req_valid = !rst && !redirect_valid && (in_use < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (discard_cnt != '0);
  assign rsp_live   = imem_rsp_valid && (discard_cnt == '0) && (live_cnt != '0);
  assign push       = rsp_live && !redirect_valid;
  assign pop        = isu_valid && isu_ready;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign isu_data = head.instr;
  assign isu_pc   = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      live_cnt    <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      // every live request becomes a discard, minus the one returning now
      fetch_pc    <= target_pc;
      rsp_pc      <= target_pc;
      live_cnt    <= '0;
      discard_cnt <= discard_cnt + live_cnt - CW'(rsp_drop || rsp_live);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + A_WIDTH'(4);
      if (rsp_live) rsp_pc   <= rsp_pc + A_WIDTH'(4);
      live_cnt    <= live_cnt + CW'(req_fire) - CW'(rsp_live);
      discard_cnt <= discard_cnt - CW'(rsp_drop);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .valid (isu_valid),
    .count (occupancy)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && discard_cnt == '0 && live_cnt == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus an instruction-stream
// reference (consecutive PCs from the latest redirect target, data = f(pc)).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned NONE   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        isu_valid;
  logic        isu_ready = 1'b1;
  logic [31:0] isu_data;
  logic [31:0] isu_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .A_WIDTH    (32),
    .D_WIDTH    (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .isu_valid      (isu_valid),
    .isu_ready      (isu_ready),
    .isu_data       (isu_data),
    .isu_pc         (isu_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mem_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc, lat_lo, lat_hi, nreq, isu_hits, wrap_hits, first_valid_cyc;
  logic [31:0] exp_pc, req_expect;
  logic        expect_idle, in_wrap, found;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic rsp_due();
    return (mem_q.size() != 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; advances one clock and returns at the next falling edge.
  task automatic cycle();
    logic        rsp_go;
    logic [31:0] tgt;
    rsp_go         = rsp_due();
    imem_rsp_valid = rsp_go;
    imem_rsp_data  = rsp_go ? instr_of(mem_q[0].addr) : '0;
    #1;
    if (redirect_valid) check("req_in_redirect", imem_req_valid, 1'b0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, req_expect);
      req_expect = req_expect + 32'd4;
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
      nreq++;
    end
    if (rsp_go) void'(mem_q.pop_front());
    if (expect_idle) check("isu_after_redirect", isu_valid, 1'b0);
    expect_idle = redirect_valid;
    if (isu_valid && first_valid_cyc == NONE) first_valid_cyc = cyc;
    if (isu_valid && isu_ready) begin
      check("isu_pc", isu_pc, exp_pc);
      check("isu_data", isu_data, instr_of(exp_pc));
      if (in_wrap && isu_pc == 32'h0) wrap_hits++;
      exp_pc = exp_pc + 32'd4;
      isu_hits++;
    end
    if (redirect_valid) begin
      tgt        = {redirect_pc[31:2], 2'b00};
      exp_pc     = tgt;
      req_expect = tgt;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asserts rst between edges, checks the immediate output response, releases at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_isu_valid", isu_valid, 1'b0);
    check("rst_isu_data", isu_data, 32'h0);
    check("rst_isu_pc", isu_pc, 32'h0);
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst             = 1'b0;
    cyc             = 0;
    exp_pc          = RST_PC;
    req_expect      = RST_PC;
    expect_idle     = 1'b0;
    first_valid_cyc = NONE;
  endtask

  initial begin
    in_wrap = 1'b0;
    wrap_hits = 0;
    lat_lo = 1; lat_hi = 1;

    // Streaming with 1-cycle memory
    apply_reset();
    isu_ready = 1'b1; isu_hits = 0;
    repeat (20) cycle();
    check("first_valid_cycle", first_valid_cyc, 2);
    check("throughput", isu_hits, 18);

    // Stall from reset: credits run out after four requests
    apply_reset();
    isu_ready = 1'b0; nreq = 0;
    repeat (12) cycle();
    check("stall_reqs", nreq, 4);
    #1;
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_isu_valid", isu_valid, 1'b1);
    isu_ready = 1'b1;
    cycle();
    #1;
    check("resume_valid", imem_req_valid, 1'b1);
    check("resume_addr", imem_req_addr, 32'h10);
    isu_hits = 0;
    repeat (10) cycle();
    check("drain_count", (isu_hits >= 4), 1'b1);

    // 3-cycle memory: redirect with two buffered and two live
    apply_reset();
    isu_ready = 1'b0; lat_lo = 3; lat_hi = 3;
    repeat (5) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    isu_ready = 1'b1; isu_hits = 0;
    repeat (16) cycle();
    check("redirect_progress", (isu_hits != 0), 1'b1);

    // Unaligned redirect target
    lat_lo = 1; lat_hi = 1;
    repeat (8) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("align_valid", imem_req_valid, 1'b1);
    check("align_addr", imem_req_addr, 32'h100);
    repeat (6) cycle();

    // Redirect coinciding with a response and an isu pop
    lat_lo = 2; lat_hi = 2;
    repeat (6) cycle();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rsp_due() && isu_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h200; found = 1'b1;
      end
      cycle();
      redirect_valid = 1'b0;
    end
    check("same_cycle_hit", found, 1'b1);
    isu_hits = 0;
    repeat (12) cycle();
    check("same_cycle_progress", (isu_hits != 0), 1'b1);

    // Address wrap at the top of the space
    lat_lo = 1; lat_hi = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    cycle();
    redirect_valid = 1'b0;
    in_wrap = 1'b1;
    repeat (12) cycle();
    in_wrap = 1'b0;
    check("wrap_seen", (wrap_hits != 0), 1'b1);

    // Reset mid-stream, then restart from RESET_PC
    lat_lo = 1; lat_hi = 3;
    repeat (5) cycle();
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    repeat (10) cycle();
    check("restart_latency", first_valid_cyc, 2);

    // Randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      isu_ready      = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom();
      cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    isu_ready      = 1'b1;
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction register and decode.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents them downstream over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

Parameters:
- A_WIDTH, 32, address/PC width.
- D_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, instruction buffer entries and max in-flight budget; power of two, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  A_WIDTH  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; in request order, latency >=1 cycle.
- imem_rsp_data  in  D_WIDTH  instruction word.
- isu_valid  out  1  instruction available to decode.
- isu_ready  in  1  decode accepts instruction.
- isu_data  out  D_WIDTH  instruction at FIFO head.
- isu_pc  out  A_WIDTH  PC of isu_data.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  A_WIDTH  new fetch address; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, live_cnt=0, discard_cnt=0.
  - Outputs during reset: imem_req_valid=0, isu_valid=0, isu_data=0, isu_pc=0.
  - Reset mid-operation abandons all in-flight state; the memory shares rst, so no stale responses follow.
- Credit rule: imem_req_valid = !redirect_valid && (occupancy + live_cnt + discard_cnt < FIFO_DEPTH). imem_req_addr = fetch_pc.
- Request handshake (valid && ready):
  - fetch_pc += 4, wrapping modulo 2^A_WIDTH.
  - live_cnt++.
- Response handling:
  - If discard_cnt>0: discard_cnt--, data dropped.
  - Else if live_cnt>0: push {rsp_pc, data}, rsp_pc += 4, live_cnt--.
  - Else: protocol error; ignore the response and fire a simulation assertion.
  - Push cannot overflow by the credit rule; any violation fires an assertion.
- Output:
  - isu_valid = FIFO non-empty; isu_data/isu_pc = head entry; registered.
  - A pushed entry appears the cycle after the response edge.
  - Pop on isu_valid && isu_ready.
- Throughput: one instruction per cycle sustained with 1-cycle memory and isu_ready=1.
- First-instruction latency: request in cycle 0 after reset release, response in cycle 1, isu_valid in cycle 2.
- Redirect (registered effect, takes priority over everything):
  - FIFO cleared.
  - fetch_pc = rsp_pc = {redirect_pc[A_WIDTH-1:2],2'b00}.
  - discard_cnt = discard_cnt + live_cnt + (req handshake ? 1 : 0) - (rsp_valid ? 1 : 0). No request is issued in a redirect cycle, so the req term is 0.
  - live_cnt = 0.
  - A same-cycle response is always dropped.
  - A same-cycle isu handshake counts as consumed by decode; the FIFO is cleared regardless.
  - isu_valid=0 the following cycle.
- Back-to-back redirects: the last one wins; discard accounting accumulates.
- Counter width: $clog2(FIFO_DEPTH)+1 bits for occupancy, live_cnt, and discard_cnt.
- Stall (isu_ready=0): FIFO fills, then requests stop once credits are exhausted. No data is lost and no duplicates are produced.

Decomposition:
- Shared package cpu_pkg:
  - D_WIDTH, A_WIDTH, RESET_PC.
  - OP_CODE/FUNCT3/FUNCT7/OP sizes.
  - Typedef fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo.
  - Synchronous FIFO of fetch_entry_t with push, pop, flush, and occupancy.
  - Flush has priority over push.
  - Async active-high reset.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory returning addr-derived data, isu_ready=1 -> imem_req_addr 0,4,8,...; isu_pc 0,4,8,... from cycle 2, one per cycle, no gaps.
- isu_ready=0 from reset -> exactly 4 requests (0x0-0xC), then imem_req_valid=0; occupancy 4. Raise ready -> drains 0x0,0x4,0x8,0xC, then fetch resumes at 0x10.
- 3-cycle memory with 2 live in flight and 2 buffered; redirect_pc=0x100 -> isu_valid=0 next cycle; the 2 stale responses are dropped; first isu_pc=0x100 with correct data.
- redirect_pc=0x103 -> imem_req_addr=0x100.
- Redirect in the same cycle as rsp_valid and an isu pop -> response dropped, discard_cnt correct; no stale PC ever reaches isu_pc.
- fetch_pc=0xFFFF_FFFC -> next address 0x0.
- rst asserted mid-stream between clock edges -> isu_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_PC.
